serial_full_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: diff = a - b - bin, computed LSB-first,
//   one bit per enabled clock, through a single full-subtractor cell and a

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor_cell.sv | 25 ++
 rtl/serial_full_subtractor.sv | 108 ++++++++++
 tb/tb_serial_full_subtractor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// FSM state encoding; 2'd3 is unused and recovers to idle.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor built from gate primitives.
// d = a ^ b ^ bin, bo = (~a & b) | (~(a ^ b) & bin).
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic t;
  logic na;
  logic nt;
  logic x1;
  logic x2;

  xor g_t  (t, a, b);
  xor g_d  (d, t, bin);
  not g_na (na, a);
  and g_x1 (x1, na, b);
  not g_nt (nt, t);
  and g_x2 (x2, nt, bin);
  or  g_bo (bo, x1, x2);

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per enabled clock.
// One full-subtractor cell plus a registered borrow.
module serial_full_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             accept;
  logic             cell_d;
  logic             cell_bo;

  full_subtractor_cell u_cell (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // Next-state: accept/load, one bit step per enabled SHIFT cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    accept   = ena & start &
               ((state_q == S_IDLE) | (state_q == S_DONE));
    if (accept) begin
      state_d  = S_SHIFT;
      cnt_d    = '0;
      opa_d    = a;
      opb_d    = b;
      borrow_d = bin;
      diff_d   = '0;
      bout_d   = 1'b0;
    end else if (ena) begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_SHIFT: begin
          diff_d   = {cell_d, diff_q[WIDTH-1:1]};
          opa_d    = opa_q >> 1;
          opb_d    = opb_q >> 1;
          borrow_d = cell_bo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bout_d  = cell_bo;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Scoreboard bench for serial_full_subtractor.
// Expected results come from plain (WIDTH+1)-bit arithmetic.
module tb_serial_full_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena   = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         bout;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W:0] sb[$];
  logic [W:0] exp_v;
  logic       done_prev = 1'b0;

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Reference: {borrow, diff} is the (W+1)-bit value of a - b - bin.
  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ai,
                       input logic [W-1:0] bi,
                       input logic ci);
    a     = ai;
    b     = bi;
    bin   = ci;
    ena   = 1'b1;
    start = 1'b1;
    sb.push_back(model(ai, bi, ci));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, input bit rnd_stall);
    n = 0;
    while (!done && n < 100) begin
      if (rnd_stall) ena = ($urandom_range(3) != 0);
      tick();
      n++;
    end
    ena = 1'b1;
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare each new done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_v = sb.pop_front();
        check("diff", 32'(diff), 32'(exp_v[W-1:0]));
        check("bout", 32'(bout), 32'(exp_v[W]));
      end
    end
    done_prev = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    issue(8'd100, 8'd37, 1'b0);
    check("busy_shift", 32'(busy), 32'd1);
    wait_done(n, 1'b0);
    check("lat_case1", 32'(n), 32'd8);
    check("busy_in_done", 32'(busy), 32'd0);
    ena = 1'b0;
    tick();
    tick();
    check("done_held", 32'(done), 32'd1);
    ena = 1'b1;
    tick();
    check("done_cleared", 32'(done), 32'd0);

    issue(8'd5, 8'd10, 1'b0);
    wait_done(n, 1'b0);
    issue(8'd0, 8'd0, 1'b1);
    wait_done(n, 1'b0);
    issue(8'd255, 8'd255, 1'b0);
    wait_done(n, 1'b0);

    issue(8'd100, 8'd37, 1'b0);
    tick();
    tick();
    ena = 1'b0;
    repeat (3) tick();
    ena   = 1'b1;
    start = 1'b1;
    a     = 8'd7;
    b     = 8'd9;
    tick();
    start = 1'b0;
    wait_done(n, 1'b0);
    check("lat_stall", 32'(n + 6), 32'd11);

    a     = 8'd100;
    b     = 8'd37;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(8'd200, 8'd1, 1'b0);
    wait_done(n, 1'b0);
    tick();

    issue(8'd100, 8'd37, 1'b0);
    wait_done(n, 1'b0);
    issue(8'd1, 8'd2, 1'b0);
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n, 1'b0);
    check("b2b_gap", 32'(n + 1), 32'd9);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if ($urandom_range(7) == 0) ra = '0;
      if ($urandom_range(7) == 0) rb = '1;
      issue(ra, rb, rc);
      wait_done(n, 1'b1);
      if ($urandom_range(1) == 1) tick();
    end

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
